// File: rtl/perm_pipe.sv
// perm_pipe: bit-permutation unit followed by an elastic register pipeline.
// A static permutation, or its inverse, is applied combinationally ahead of
// stage 0. The {valid, data, inv} triple then moves through STAGES register
// stages under ready/valid flow control with no internal bubbles.
module perm_pipe #(
    parameter int WIDTH  = 32,
    parameter int IDXW   = 5,
    parameter int STAGES = 2,
    // Field i holds the source bit index for output bit i (DES P by default).
    parameter logic [WIDTH*IDXW-1:0] PERM = {
        5'd16, 5'd25, 5'd12, 5'd11, 5'd3,  5'd20, 5'd4,  5'd15,
        5'd31, 5'd17, 5'd9,  5'd6,  5'd27, 5'd14, 5'd1,  5'd22,
        5'd30, 5'd24, 5'd8,  5'd18, 5'd0,  5'd5,  5'd29, 5'd23,
        5'd13, 5'd19, 5'd2,  5'd26, 5'd10, 5'd21, 5'd28, 5'd7
    }
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_inv
);

    // A table is accepted only if every field is in range and no source
    // index is used twice; with WIDTH fields that makes it a bijection.
    function automatic bit perm_is_bijective();
        logic [WIDTH-1:0] seen;
        logic [WIDTH-1:0] probe;
        int               src;
        bit               ok;
        seen = '0;
        ok   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            src = int'(PERM[i*IDXW +: IDXW]);
            if (src >= WIDTH) begin
                ok = 1'b0;
            end else begin
                probe = seen >> src;
                if (probe[0]) begin
                    ok = 1'b0;
                end
                seen = seen | ({{(WIDTH-1){1'b0}}, 1'b1} << src);
            end
        end
        return ok;
    endfunction

    localparam bit PERM_OK = perm_is_bijective();

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("perm_pipe: WIDTH must be in 2..64");
    end
    if (IDXW < $clog2(WIDTH)) begin : g_bad_idxw
        $error("perm_pipe: IDXW is too narrow to index WIDTH bits");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("perm_pipe: STAGES must be in 1..4");
    end
    if (!PERM_OK) begin : g_bad_perm
        $error("perm_pipe: PERM is not a bijection onto 0..WIDTH-1");
    end

    logic [WIDTH-1:0] fwd_res;
    logic [WIDTH-1:0] inv_res;
    logic [WIDTH-1:0] perm_res;

    // Both directions are pure wiring; the inverse scatters input bit i to
    // position PERM[i], which is a single driver per bit because PERM is a
    // bijection.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int SRC = int'(PERM[i*IDXW +: IDXW]);
        assign fwd_res[i]   = in_data[SRC];
        assign inv_res[SRC] = in_data[i];
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] inv_q, inv_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic              rdy_en_q, rdy_en_d;
    logic [STAGES-1:0] adv;
    logic              in_xfer;

    // Mode select for the beat being offered this cycle.
    always_comb begin
        perm_res = in_inv ? inv_res : fwd_res;
    end

    // Advance chain: a stage may load when it is empty or its contents move
    // on, so ready ripples back from out_ready in the same cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    // Input handshake; rdy_en_q keeps ready low until the first edge after
    // reset release, and flush blocks any new beat.
    always_comb begin
        in_ready = adv[0] && rdy_en_q && !flush;
        in_xfer  = in_valid && in_ready;
    end

    // Next-state for every stage; data only loads with a valid beat so a
    // stalled or idle stage keeps its contents.
    always_comb begin
        valid_d  = valid_q;
        inv_d    = inv_q;
        data_d   = data_q;
        rdy_en_d = 1'b1;
        if (adv[0]) begin
            valid_d[0] = in_xfer;
            if (in_xfer) begin
                data_d[0] = perm_res;
                inv_d[0]  = in_inv;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    inv_d[k]  = inv_q[k-1];
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Stage registers; reset clears everything so outputs read zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            inv_q    <= '0;
            rdy_en_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            inv_q    <= inv_d;
            rdy_en_q <= rdy_en_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Outputs come straight from the last stage.
    always_comb begin
        out_valid = valid_q[STAGES-1];
        out_data  = data_q[STAGES-1];
        out_inv   = inv_q[STAGES-1];
    end

endmodule

// File: tb/tb_perm_pipe.sv
module tb_perm_pipe;

    localparam int STAGES = 2;
    // Sources for out[31] down to out[0].
    localparam int P_HI [32] = '{16, 25, 12, 11, 3, 20, 4, 15, 31, 17, 9, 6, 27, 14, 1, 22,
                                 30, 24, 8, 18, 0, 5, 29, 23, 13, 19, 2, 26, 10, 21, 28, 7};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_inv = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_inv;

    int checks = 0;
    int errors = 0;

    perm_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] din;
        logic        inv;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    logic [31:0] s_din  [128];
    logic        s_inv  [128];
    logic [31:0] s_exp  [128];
    logic [31:0] s_got  [128];
    logic [31:0] s_orig [128];

    function automatic logic [31:0] model(input logic [31:0] x, input logic inv);
        logic [31:0] y;
        int          src;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            src = P_HI[31-i];
            if (!inv) y[i] = x[src];
            else      y[src] = x[i];
        end
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats from s_din/s_inv, holding out_ready low for the first
    // 'stall' cycles, and checks every output against s_exp in order.
    task automatic run_stream(input int n, input int stall, input string tag);
        int  sent = 0;
        int  rcv = 0;
        int  cyc = 0;
        int  ready_miss = 0;
        bit  in_acc;
        while (rcv < n && cyc < n + stall + 50) begin
            in_valid  = (sent < n);
            in_data   = (sent < n) ? s_din[sent] : 32'h0;
            in_inv    = (sent < n) ? s_inv[sent] : 1'b0;
            out_ready = (cyc >= stall);
            #1;
            in_acc = in_valid && in_ready;
            if (stall == 0 && in_valid && !in_ready) ready_miss++;
            if (stall > 0 && cyc == stall) check({tag, " accepts_during_stall"}, 64'(sent), 64'(STAGES));
            if (out_valid && out_ready) begin
                check({tag, " data"}, {32'h0, out_data}, {32'h0, s_exp[rcv]});
                check({tag, " inv"}, {63'h0, out_inv}, {63'h0, s_inv[rcv]});
                s_got[rcv] = out_data;
                rcv++;
            end else if (out_valid && rcv < n) begin
                check({tag, " stall_hold"}, {32'h0, out_data}, {32'h0, s_exp[rcv]});
            end
            @(posedge clk);
            if (in_acc) sent++;
            cyc++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, " beats_out"}, 64'(rcv), 64'(n));
        if (stall == 0) begin
            check({tag, " ready_gaps"}, 64'(ready_miss), 64'd0);
            check({tag, " cycles"}, 64'(cyc), 64'(n + STAGES));
        end
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0001, 1'b0, 32'h0000_0800};
        vecs[1]  = '{32'h8000_0000, 1'b0, 32'h0080_0000};
        vecs[2]  = '{32'h0000_0800, 1'b1, 32'h0000_0001};
        vecs[3]  = '{32'h0080_0000, 1'b1, 32'h8000_0000};
        vecs[4]  = '{32'h0000_0002, 1'b0, 32'h0002_0000};
        vecs[5]  = '{32'h0002_0000, 1'b1, 32'h0000_0002};
        vecs[6]  = '{32'h0000_0080, 1'b0, 32'h0000_0001};
        vecs[7]  = '{32'h0000_0001, 1'b1, 32'h0000_0080};
        vecs[8]  = '{32'h0001_0000, 1'b0, 32'h8000_0000};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[10] = '{32'h0000_0000, 1'b0, 32'h0000_0000};

        // Reset state
        step();
        step();
        check("rst out_valid", {63'h0, out_valid}, 64'h0);
        check("rst out_data", {32'h0, out_data}, 64'h0);
        check("rst out_inv", {63'h0, out_inv}, 64'h0);
        check("rst in_ready", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel in_ready_before_edge", {63'h0, in_ready}, 64'h0);
        step();
        check("rel in_ready_after_edge", {63'h0, in_ready}, 64'h1);

        // Directed single beats with exact latency
        foreach (vecs[v]) begin
            in_valid = 1'b1;
            in_data  = vecs[v].din;
            in_inv   = vecs[v].inv;
            #1;
            check($sformatf("vec%0d in_ready", v), {63'h0, in_ready}, 64'h1);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d early_valid", v), {63'h0, out_valid}, 64'h0);
            step();
            check($sformatf("vec%0d out_valid", v), {63'h0, out_valid}, 64'h1);
            check($sformatf("vec%0d out_data", v), {32'h0, out_data}, {32'h0, vecs[v].exp});
            check($sformatf("vec%0d out_inv", v), {63'h0, out_inv}, {63'h0, vecs[v].inv});
            step();
            check($sformatf("vec%0d drained", v), {63'h0, out_valid}, 64'h0);
        end

        // 100 back-to-back forward beats, then the results fed back inverted
        for (int i = 0; i < 100; i++) begin
            s_din[i]  = $urandom;
            s_orig[i] = s_din[i];
            s_inv[i]  = 1'b0;
            s_exp[i]  = model(s_din[i], 1'b0);
        end
        run_stream(100, 0, "fwd_stream");
        for (int i = 0; i < 100; i++) begin
            s_din[i] = s_got[i];
            s_inv[i] = 1'b1;
            s_exp[i] = s_orig[i];
        end
        run_stream(100, 0, "inv_roundtrip");

        // Stall: out_ready low for 5 cycles with input pending, mixed modes
        for (int i = 0; i < 6; i++) begin
            s_din[i] = $urandom;
            s_inv[i] = 1'(i % 2);
            s_exp[i] = model(s_din[i], s_inv[i]);
        end
        run_stream(6, 5, "stall");

        // Flush with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = 32'h1234_5678;
        step();
        in_data   = 32'h9ABC_DEF0;
        step();
        check("flush preload out_valid", {63'h0, out_valid}, 64'h1);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        #1;
        check("flush in_ready", {63'h0, in_ready}, 64'h0);
        step();
        flush    = 1'b0;
        check("flush out_valid", {63'h0, out_valid}, 64'h0);
        in_data  = 32'h0000_0001;
        #1;
        check("post_flush in_ready", {63'h0, in_ready}, 64'h1);
        step();
        in_valid = 1'b0;
        check("post_flush early_valid", {63'h0, out_valid}, 64'h0);
        step();
        check("post_flush out_valid", {63'h0, out_valid}, 64'h1);
        check("post_flush out_data", {32'h0, out_data}, 64'h0000_0800);
        step();
        check("post_flush drained", {63'h0, out_valid}, 64'h0);

        // Reset pulsed mid-stream
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_inv   = 1'b1;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {63'h0, out_valid}, 64'h0);
        check("midrst out_data", {32'h0, out_data}, 64'h0);
        check("midrst out_inv", {63'h0, out_inv}, 64'h0);
        check("midrst in_ready", {63'h0, in_ready}, 64'h0);
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst rel in_ready_before_edge", {63'h0, in_ready}, 64'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("midrst no_ghost%0d", c), {63'h0, out_valid}, 64'h0);
        end
        check("midrst in_ready_after", {63'h0, in_ready}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perm_pipe.md
PERM_PIPE -- requirements
Module: perm_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (2..64).
REQ-002 SHALL have parameter IDXW, default 5, index width, equal to ceil(log2(WIDTH)).
REQ-003 SHALL have parameter STAGES, default 2, pipeline register depth (1..4).
REQ-004 SHALL have parameter PERM, WIDTH*IDXW bits, permutation table: field [i*IDXW +: IDXW] = source bit index for output bit i.
- Default encodes the DES P permutation.
- Sources for out[31] down to out[0]: 16,25,12,11,3,20,4,15,31,17,9,6,27,14,1,22,30,24,8,18,0,5,29,23,13,19,2,26,10,21,28,7.
REQ-005 SHALL have port clk, input, 1, the single clock; the block is rising-edge triggered.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port flush, input, 1, synchronous clear of all in-flight data.
REQ-008 SHALL have port in_valid, input, 1, input beat present.
REQ-009 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-010 SHALL have port in_data, input, WIDTH, data to permute.
REQ-011 SHALL have port in_inv, input, 1: 0 = forward permutation, 1 = inverse permutation; it travels with its beat.
REQ-012 SHALL have port out_valid, output, 1, output beat present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts.
REQ-014 SHALL have port out_data, output, WIDTH, permuted data.
REQ-015 SHALL have port out_inv, output, 1, in_inv of the beat currently on out_data.

Function
REQ-016 SHALL compute forward mode as out[i] = in[PERM[i]] for every i.
REQ-017 SHALL compute inverse mode as out[PERM[i]] = in[i] for every i.
REQ-018 SHALL apply the permutation combinationally ahead of stage 0, registering the result and its mode bit into stage 0.
REQ-019 SHALL consist of STAGES register stages, each holding {valid, data, inv}; out_* SHALL be driven directly from the last stage.
REQ-020 SHALL transfer a beat on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-021 SHALL advance stage k when it is empty, or when stage k+1 advances or is empty; the last stage SHALL advance when it is empty or out_ready=1.
REQ-022 SHALL drive in_ready = stage 0 advances.
- in_ready SHALL depend on out_ready combinationally, with no internal bubble.
- Full throughput is one beat per cycle.
REQ-023 SHALL have a latency of exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-024 SHALL hold out_data and out_inv stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never drop or duplicate a beat and SHALL preserve order.
REQ-026 SHALL, on flush=1, clear all stage valid bits at the next edge.
- in_ready SHALL be 0 during flush.
- An in_valid beat presented that cycle SHALL be discarded.
- flush SHALL override out_ready.
REQ-027 SHALL, when out_ready toggles while the pipeline is full, leave the stalled data unchanged and resume in order.
REQ-028 SHALL make a non-bijective PERM, or any field >= WIDTH, an elaboration error; IDXW < ceil(log2(WIDTH)) SHALL also be an elaboration error.

Reset
REQ-029 SHALL, while rst_n=0, force all stage valid, data and inv registers to 0, giving out_valid=0, out_data=0, out_inv=0.
REQ-030 SHALL drive in_ready=0 while rst_n=0 and 1 from the first clock edge after release.
REQ-031 SHALL discard in-flight beats when reset is asserted mid-operation, with no partial output.

Verification
REQ-032 SHALL pass this directed scenario with default parameters: forward 0x00000001 -> 0x00000800 after 2 cycles; forward 0x80000000 -> 0x00800000.
REQ-033 SHALL pass this directed scenario: inverse 0x00000800 -> 0x00000001; inverse 0x00800000 -> 0x80000000; out_inv=1 on both.
REQ-034 SHALL pass this directed scenario: 100 back-to-back random beats with out_ready=1 -> one output per cycle, in order, and forward followed by inverse equals the original.
REQ-035 SHALL pass this directed scenario: out_ready held 0 for 5 cycles with in_valid=1 -> in_ready falls after STAGES accepts, out_data stays stable, and all beats emerge after release.
REQ-036 SHALL pass this directed scenario: flush asserted with 2 beats in flight -> out_valid=0 the next cycle, and the next accepted beat emerges with latency 2.
REQ-037 SHALL pass this directed scenario: rst_n pulsed low mid-stream -> all outputs read 0 asynchronously, and no pre-reset beat appears afterwards.
